piece_controller: RTL and testbench
===================================

Name: piece_controller

Overview:
- Sequences the active falling piece and owns the 128-bit playfield.
- Spawns pieces and applies gravity ticks and player move/rotate requests, gated by the combinational legality flags from the boundary checker.
- Locks landed pieces into the board, clears full rows with compaction, and flags game over.
- Sits between input debounce/tick generation and the boundary checker and renderer. Its board and block position/type outputs feed both.

Parameters:
- BOARD_W, 8, board width in cells; must equal `BOARD_BLOCK_W.
- BOARD_H, 16, board height in cells; must equal `BOARD_BLOCK_H; BOARD_W*BOARD_H = 128.
- SPAWN_X, 3, spawn column; must satisfy 1 <= SPAWN_X <= BOARD_W-2.
- SPAWN_Y, 1, spawn row; must be >= 1 so a vertical I piece fits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- drop_tick  in  1  one-cycle gravity pulse.
- btn_left  in  1  one-cycle move-left request.
- btn_right  in  1  one-cycle move-right request.
- btn_down  in  1  one-cycle soft-drop request.
- btn_rotate  in  1  one-cycle rotate request.
- next_type  in  8  piece type to spawn; sampled in SPAWN.
- can_move_down  in  1  legality flag from boundary checker, same cycle.
- can_move_left  in  1  legality flag from boundary checker, same cycle.
- can_move_right  in  1  legality flag from boundary checker, same cycle.
- can_rotate  in  1  legality flag from boundary checker, same cycle.
- board  out  128  occupied cells; bit index = x + BOARD_W*y, row 0 at top.
- block_xpos  out  8  active piece pivot column.
- block_ypos  out  8  active piece pivot row.
- block_type  out  8  `BLOCK_SINGLE / `BLOCK_I_VERTICAL / `BLOCK_I_HORRIZONTAL.
- piece_valid  out  1  high while a piece is falling (FALL state).
- lines_cleared  out  16  total rows cleared; saturates at 65535.
- game_over  out  1  sticky until reset.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: board=0, block_xpos=SPAWN_X, block_ypos=SPAWN_Y, block_type=`BLOCK_SINGLE, piece_valid=0, lines_cleared=0, game_over=0, state=SPAWN.
- Reset asserted mid-operation (including CLEAR) discards all progress immediately.
- Piece footprint about pivot (x,y):
  - SINGLE: (x,y).
  - I_VERTICAL: (x,y-1), (x,y), (x,y+1).
  - I_HORRIZONTAL: (x-1,y), (x,y), (x+1,y).
- SPAWN (1 cycle): latch next_type; any unrecognised code becomes `BLOCK_SINGLE. Load x=SPAWN_X, y=SPAWN_Y.
  - If any footprint cell is occupied: go to OVER, set game_over=1.
  - Otherwise: go to FALL, set piece_valid=1.
- FALL: at most one action per cycle. Priority, highest first:
  - drop_tick or btn_down: if can_move_down, y+1; else go to LOCK.
  - btn_rotate: if can_rotate, swap I_VERTICAL and I_HORRIZONTAL; SINGLE never rotates.
  - btn_left: if can_move_left, x-1.
  - btn_right: if can_move_right, x+1.
  - Lower-priority requests in the same cycle are dropped, not queued.
  - A rejected request leaves all outputs unchanged.
- LOCK (1 cycle): OR the footprint into board; piece_valid=0; set scan row r=BOARD_H-1; go to CLEAR.
- CLEAR: one row evaluated per cycle.
  - Row r full (all BOARD_W bits set): shift rows 0..r-1 down by one in a single cycle, zero row 0, increment lines_cleared (saturating), keep r unchanged so the shifted row is rechecked.
  - Row r not full: if r==0 go to SPAWN, else r-1.
  - Worst-case CLEAR latency is BOARD_H + number of cleared rows cycles.
- OVER: sticky. All inputs ignored, board frozen, piece_valid=0. Exit only by reset.
- Inputs are ignored in SPAWN, LOCK, CLEAR and OVER.
- Legality flags are combinational from the current outputs and trusted as-is. The controller never writes a cell outside the board given correct flags.

Test Plan:
- Reset, then SPAWN with next_type=SINGLE -> piece_valid=1, x=3, y=1, board=0, lines_cleared=0 on the 2nd cycle after reset release.
- SINGLE, 14 drop_ticks -> y=15. 15th tick -> LOCK: board bit 123 set, piece respawns at (3,1), lines_cleared=0.
- Eight SINGLEs each steered to columns 0..7 and dropped -> after the 8th lock, row 15 clears: board=0, lines_cleared=1.
- I_VERTICAL with btn_rotate and can_rotate=0 -> type unchanged. Same with can_rotate=1 -> I_HORRIZONTAL. Same cycle drop_tick+btn_left -> only y+1 applied.
- Stack SINGLEs in column 3 until (3,1) is occupied -> next SPAWN sets game_over=1, piece_valid=0; further buttons and ticks leave board unchanged.
- Assert rst during CLEAR of a full row -> board=0, lines_cleared=0, game_over=0 immediately (asynchronous), normal SPAWN after release.

Source files
------------

// File: rtl/piece_controller.sv
// Active falling-piece sequencer and 128-cell playfield owner.
// Handles spawn, gravity/move/rotate, lock, row clearing with compaction, and game over.
module piece_controller #(
  parameter int unsigned BOARD_W = 8,
  parameter int unsigned BOARD_H = 16,
  parameter int unsigned SPAWN_X = 3,
  parameter int unsigned SPAWN_Y = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drop_tick,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_down,
  input  logic         btn_rotate,
  input  logic [7:0]   next_type,
  input  logic         can_move_down,
  input  logic         can_move_left,
  input  logic         can_move_right,
  input  logic         can_rotate,
  output logic [127:0] board,
  output logic [7:0]   block_xpos,
  output logic [7:0]   block_ypos,
  output logic [7:0]   block_type,
  output logic         piece_valid,
  output logic [15:0]  lines_cleared,
  output logic         game_over
);

  localparam int unsigned CELLS = BOARD_W * BOARD_H;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned ROW_W = $clog2(BOARD_H);

  localparam logic [7:0] BLOCK_SINGLE        = 8'd0;
  localparam logic [7:0] BLOCK_I_VERTICAL    = 8'd1;
  localparam logic [7:0] BLOCK_I_HORRIZONTAL = 8'd2;

  localparam logic [2:0] ST_SPAWN = 3'd0;
  localparam logic [2:0] ST_FALL  = 3'd1;
  localparam logic [2:0] ST_LOCK  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0]       r_state;
  logic [CELLS-1:0] r_board;
  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic [7:0]       r_type;
  logic             r_valid;
  logic [15:0]      r_lines;
  logic             r_over;
  logic [ROW_W-1:0] r_row;

  logic [2:0]       w_state;
  logic [CELLS-1:0] w_board;
  logic [7:0]       w_x;
  logic [7:0]       w_y;
  logic [7:0]       w_type;
  logic             w_valid;
  logic [15:0]      w_lines;
  logic             w_over;
  logic [ROW_W-1:0] w_row;

  logic [7:0]       w_spawn_type;
  logic [CELLS-1:0] w_spawn_fp;
  logic [CELLS-1:0] w_active_fp;
  logic [BOARD_W-1:0] w_scan_row;
  logic             w_row_full;
  logic [CELLS-1:0] w_shifted;

  // Cells covered by a piece of type t with pivot (x,y); off-board cells are dropped.
  function automatic logic [CELLS-1:0] f_footprint(input logic [7:0] t,
                                                   input logic [7:0] x,
                                                   input logic [7:0] y);
    logic [CELLS-1:0] m;
    logic             use_cell;
    int               cx;
    int               cy;
    m = '0;
    for (int k = -1; k <= 1; k++) begin
      use_cell = (k == 0) || (t == BLOCK_I_VERTICAL) || (t == BLOCK_I_HORRIZONTAL);
      cx = int'(x) + ((t == BLOCK_I_HORRIZONTAL) ? k : 0);
      cy = int'(y) + ((t == BLOCK_I_VERTICAL) ? k : 0);
      if (use_cell && cx >= 0 && cx < int'(BOARD_W) && cy >= 0 && cy < int'(BOARD_H))
        m[IDX_W'(cy * int'(BOARD_W) + cx)] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    w_spawn_type = BLOCK_SINGLE;
    if (next_type == BLOCK_I_VERTICAL || next_type == BLOCK_I_HORRIZONTAL)
      w_spawn_type = next_type;
  end

  assign w_spawn_fp  = f_footprint(w_spawn_type, 8'(SPAWN_X), 8'(SPAWN_Y));
  assign w_active_fp = f_footprint(r_type, r_x, r_y);

  // Scan-row extraction and the one-cycle compaction of rows 0..r_row.
  always_comb begin
    w_scan_row = '0;
    w_shifted  = r_board;
    for (int i = 0; i < int'(BOARD_H); i++) begin
      if (ROW_W'(i) == r_row)
        w_scan_row = r_board[i*BOARD_W +: BOARD_W];
      if (ROW_W'(i) <= r_row) begin
        if (i == 0)
          w_shifted[0 +: BOARD_W] = '0;
        else
          w_shifted[i*BOARD_W +: BOARD_W] = r_board[(i-1)*BOARD_W +: BOARD_W];
      end
    end
  end

  assign w_row_full = &w_scan_row;

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_board = r_board;
    w_x     = r_x;
    w_y     = r_y;
    w_type  = r_type;
    w_valid = r_valid;
    w_lines = r_lines;
    w_over  = r_over;
    w_row   = r_row;
    case (r_state)
      ST_SPAWN: begin
        w_type = w_spawn_type;
        w_x    = 8'(SPAWN_X);
        w_y    = 8'(SPAWN_Y);
        if (|(r_board & w_spawn_fp)) begin
          w_state = ST_OVER;
          w_over  = 1'b1;
          w_valid = 1'b0;
        end else begin
          w_state = ST_FALL;
          w_valid = 1'b1;
        end
      end
      ST_FALL: begin
        if (drop_tick || btn_down) begin
          if (can_move_down)
            w_y = r_y + 8'd1;
          else
            w_state = ST_LOCK;
        end else if (btn_rotate) begin
          if (can_rotate) begin
            if (r_type == BLOCK_I_VERTICAL)
              w_type = BLOCK_I_HORRIZONTAL;
            else if (r_type == BLOCK_I_HORRIZONTAL)
              w_type = BLOCK_I_VERTICAL;
          end
        end else if (btn_left) begin
          if (can_move_left)
            w_x = r_x - 8'd1;
        end else if (btn_right) begin
          if (can_move_right)
            w_x = r_x + 8'd1;
        end
      end
      ST_LOCK: begin
        w_board = r_board | w_active_fp;
        w_valid = 1'b0;
        w_row   = ROW_W'(BOARD_H - 1);
        w_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        // A cleared row keeps r_row so the row shifted into it is rechecked.
        if (w_row_full) begin
          w_board = w_shifted;
          if (r_lines != 16'hFFFF)
            w_lines = r_lines + 16'd1;
        end else if (r_row == '0) begin
          w_state = ST_SPAWN;
        end else begin
          w_row = r_row - ROW_W'(1);
        end
      end
      ST_OVER: begin
        w_valid = 1'b0;
      end
      default: begin
        w_state = ST_SPAWN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SPAWN;
      r_board <= '0;
      r_x     <= 8'(SPAWN_X);
      r_y     <= 8'(SPAWN_Y);
      r_type  <= BLOCK_SINGLE;
      r_valid <= 1'b0;
      r_lines <= '0;
      r_over  <= 1'b0;
      r_row   <= '0;
    end else begin
      r_state <= w_state;
      r_board <= w_board;
      r_x     <= w_x;
      r_y     <= w_y;
      r_type  <= w_type;
      r_valid <= w_valid;
      r_lines <= w_lines;
      r_over  <= w_over;
      r_row   <= w_row;
    end
  end

  assign board         = r_board;
  assign block_xpos    = r_x;
  assign block_ypos    = r_y;
  assign block_type    = r_type;
  assign piece_valid   = r_valid;
  assign lines_cleared = r_lines;
  assign game_over     = r_over;

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller; the bench also plays the boundary checker
// so pieces fall and stack naturally, with per-test overrides of the legality flags.
module tb_piece_controller;

  localparam logic [7:0] T_S = 8'd0;
  localparam logic [7:0] T_V = 8'd1;
  localparam logic [7:0] T_H = 8'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         drop_tick, btn_left, btn_right, btn_down, btn_rotate;
  logic [7:0]   next_type;
  logic         can_move_down, can_move_left, can_move_right, can_rotate;
  logic [127:0] board;
  logic [7:0]   block_xpos, block_ypos, block_type;
  logic         piece_valid;
  logic [15:0]  lines_cleared;
  logic         game_over;

  logic use_model;
  logic f_down, f_left, f_right, f_rot;
  logic m_down, m_left, m_right, m_rot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piece_controller dut (
    .clk(clk), .rst(rst),
    .drop_tick(drop_tick), .btn_left(btn_left), .btn_right(btn_right),
    .btn_down(btn_down), .btn_rotate(btn_rotate), .next_type(next_type),
    .can_move_down(can_move_down), .can_move_left(can_move_left),
    .can_move_right(can_move_right), .can_rotate(can_rotate),
    .board(board), .block_xpos(block_xpos), .block_ypos(block_ypos),
    .block_type(block_type), .piece_valid(piece_valid),
    .lines_cleared(lines_cleared), .game_over(game_over)
  );

  function automatic logic cell_free(input int x, input int y, input logic [127:0] b);
    if (x < 0 || x > 7 || y < 0 || y > 15) return 1'b0;
    return !b[7'(x + 8*y)];
  endfunction

  function automatic logic fits(input logic [7:0] t, input int x, input int y,
                                input logic [127:0] b);
    case (t)
      T_V:     return cell_free(x, y-1, b) && cell_free(x, y, b) && cell_free(x, y+1, b);
      T_H:     return cell_free(x-1, y, b) && cell_free(x, y, b) && cell_free(x+1, y, b);
      default: return cell_free(x, y, b);
    endcase
  endfunction

  always_comb begin
    m_down  = fits(block_type, int'(block_xpos), int'(block_ypos) + 1, board);
    m_left  = fits(block_type, int'(block_xpos) - 1, int'(block_ypos), board);
    m_right = fits(block_type, int'(block_xpos) + 1, int'(block_ypos), board);
    m_rot   = fits((block_type == T_V) ? T_H : (block_type == T_H) ? T_V : block_type,
                   int'(block_xpos), int'(block_ypos), board);
  end

  assign can_move_down  = use_model ? m_down  : f_down;
  assign can_move_left  = use_model ? m_left  : f_left;
  assign can_move_right = use_model ? m_right : f_right;
  assign can_rotate     = use_model ? m_rot   : f_rot;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic d, input logic dn, input logic l, input logic r,
                       input logic rot);
    drop_tick = d; btn_down = dn; btn_left = l; btn_right = r; btn_rotate = rot;
    step();
    drop_tick = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_rotate = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic steer(input int col);
    for (int i = 0; i < 10 && int'(block_xpos) != col; i++) begin
      if (int'(block_xpos) > col) press(0, 0, 1, 0, 0);
      else                        press(0, 0, 0, 1, 0);
    end
    chk("steer_col", 128'(block_xpos), 128'(col));
  endtask

  task automatic drop_to_lock();
    logic last;
    last = 1'b0;
    for (int i = 0; i < 20 && !last; i++) begin
      last = !can_move_down;
      press(0, 1, 0, 0, 0);
    end
    chk("lock_timeout", 128'(last), 128'(1));
  endtask

  task automatic place_single(input int col);
    steer(col);
    drop_to_lock();
  endtask

  task automatic wait_respawn();
    int n;
    n = 0;
    while (piece_valid && n < 60) begin step(); n++; end
    while (!piece_valid && !game_over && n < 120) begin step(); n++; end
    chk("respawn_timeout", 128'(n < 120), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drop_tick = 0; btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0;
    next_type = T_S;
    use_model = 1'b1;
    f_down = 0; f_left = 0; f_right = 0; f_rot = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    chk("rst_board", board, 128'h0);
    chk("rst_x", 128'(block_xpos), 128'(3));
    chk("rst_y", 128'(block_ypos), 128'(1));
    chk("rst_type", 128'(block_type), 128'(T_S));
    chk("rst_valid", 128'(piece_valid), 128'(0));
    chk("rst_lines", 128'(lines_cleared), 128'(0));
    chk("rst_over", 128'(game_over), 128'(0));

    // First spawn
    rst = 1'b0;
    step();
    step();
    chk("spawn_valid", 128'(piece_valid), 128'(1));
    chk("spawn_x", 128'(block_xpos), 128'(3));
    chk("spawn_y", 128'(block_ypos), 128'(1));
    chk("spawn_board", board, 128'h0);

    // Gravity to the floor and lock at (3,15) -> bit 123
    repeat (14) press(1, 0, 0, 0, 0);
    chk("fall_y15", 128'(block_ypos), 128'(15));
    chk("fall_x3", 128'(block_xpos), 128'(3));
    press(1, 0, 0, 0, 0);
    wait_respawn();
    chk("lock_board", board, 128'h08000000_00000000_00000000_00000000);
    chk("respawn_valid", 128'(piece_valid), 128'(1));
    chk("respawn_y", 128'(block_ypos), 128'(1));
    chk("lock_lines", 128'(lines_cleared), 128'(0));

    // Fill row 15 with eight singles
    do_reset();
    for (int c = 0; c < 7; c++) begin
      place_single(c);
      wait_respawn();
    end
    chk("row15_partial", board, 128'h7F000000_00000000_00000000_00000000);
    chk("row15_partial_lines", 128'(lines_cleared), 128'(0));
    place_single(7);
    next_type = T_V;
    wait_respawn();
    chk("clear_board", board, 128'h0);
    chk("clear_lines", 128'(lines_cleared), 128'(1));
    chk("iv_type", 128'(block_type), 128'(T_V));

    // Rotation gating and same-cycle priority
    use_model = 1'b0;
    f_rot = 1'b0;
    press(0, 0, 0, 0, 1);
    chk("rot_reject", 128'(block_type), 128'(T_V));
    f_rot = 1'b1;
    press(0, 0, 0, 0, 1);
    chk("rot_accept", 128'(block_type), 128'(T_H));
    use_model = 1'b1;
    press(1, 0, 1, 0, 0);
    chk("prio_y", 128'(block_ypos), 128'(2));
    chk("prio_x", 128'(block_xpos), 128'(3));
    press(0, 0, 0, 1, 0);
    chk("right_x", 128'(block_xpos), 128'(4));
    use_model = 1'b0;
    f_left = 1'b0;
    press(0, 0, 1, 0, 0);
    chk("left_reject", 128'(block_xpos), 128'(4));
    use_model = 1'b1;
    press(0, 0, 1, 0, 1);
    chk("rot_over_left_type", 128'(block_type), 128'(T_V));
    chk("rot_over_left_x", 128'(block_xpos), 128'(4));

    // Stack column 3 up to the spawn cell -> game over
    next_type = T_S;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      place_single(3);
      wait_respawn();
    end
    chk("over_flag", 128'(game_over), 128'(1));
    chk("over_valid", 128'(piece_valid), 128'(0));
    chk("over_board", board, 128'h08080808_08080808_08080808_08080800);
    repeat (3) press(1, 1, 1, 1, 1);
    chk("over_frozen", board, 128'h08080808_08080808_08080808_08080800);
    chk("over_sticky", 128'(game_over), 128'(1));
    chk("over_valid2", 128'(piece_valid), 128'(0));

    // Asynchronous reset while a full row awaits clearing
    do_reset();
    for (int c = 0; c < 7; c++) begin
      place_single(c);
      wait_respawn();
    end
    place_single(7);
    step();
    chk("pre_rst_row_full", 128'(board[127:120]), 128'(8'hFF));
    chk("pre_rst_valid", 128'(piece_valid), 128'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_board", board, 128'h0);
    chk("arst_lines", 128'(lines_cleared), 128'(0));
    chk("arst_over", 128'(game_over), 128'(0));
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_rst_valid", 128'(piece_valid), 128'(1));
    chk("post_rst_board", board, 128'h0);
    chk("post_rst_y", 128'(block_ypos), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
